// File: rtl/ascon_perm_ctrl_if.sv
// Register bus and permutation-core signals of the Ascon sequencer.
// slave = the sequencer; master = host bus plus external core.
interface ascon_perm_ctrl_if;
    logic [3:0]   reg_addr;
    logic [3:0]   reg_we;
    logic [31:0]  reg_di;
    logic         reg_re;
    logic [31:0]  reg_do;
    logic         reg_wait;
    logic         perm_start;
    logic [4:0]   perm_rounds;
    logic [319:0] perm_s_in;
    logic [319:0] perm_s_out;
    logic         perm_ready;

    modport slave (
        input  reg_addr, reg_we, reg_di, reg_re, perm_s_out, perm_ready,
        output reg_do, reg_wait, perm_start, perm_rounds, perm_s_in
    );

    modport master (
        output reg_addr, reg_we, reg_di, reg_re, perm_s_out, perm_ready,
        input  reg_do, reg_wait, perm_start, perm_rounds, perm_s_in
    );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Bus-mapped sequencer for an external 320-bit Ascon permutation core:
// state buffer, round count, start/wait/capture FSM with timeout.
module ascon_perm_ctrl #(
    parameter int unsigned MAX_ROUNDS   = 12,
    parameter int unsigned RESET_ROUNDS = 12,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    ascon_perm_ctrl_if.slave      bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0]   r_state;
    logic [319:0] r_buf;
    logic [4:0]   r_rounds;
    logic [7:0]   r_cycles;
    logic         r_busy, r_done, r_err;

    logic         w_wr, w_state_wr, w_ctrl_wr, w_start_req, w_clr_err;
    logic [4:0]   w_rounds_eff;
    logic         w_rounds_ok, w_idle, w_timeout, w_err_set;
    logic [31:0]  w_rd_data;

    assign w_wr         = |bus.reg_we;
    assign w_state_wr   = w_wr && (bus.reg_addr < 4'd10);
    assign w_ctrl_wr    = w_wr && (bus.reg_addr == 4'd10);
    assign w_start_req  = w_ctrl_wr && bus.reg_we[1] && bus.reg_di[8];
    assign w_clr_err    = w_ctrl_wr && bus.reg_we[1] && bus.reg_di[9];
    // A start in the same write as a rounds update uses the new count
    assign w_rounds_eff = bus.reg_we[0] ? bus.reg_di[4:0] : r_rounds;
    assign w_rounds_ok  = (w_rounds_eff != 5'd0) && (w_rounds_eff <= 5'(MAX_ROUNDS));
    assign w_idle       = (r_state == S_IDLE);
    assign w_timeout    = (r_state == S_WAIT) && !bus.perm_ready && (r_cycles == 8'(TIMEOUT));
    assign w_err_set    = (w_idle ? (w_start_req && !w_rounds_ok)
                                  : (w_state_wr || w_start_req)) || w_timeout;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_rounds <= 5'(RESET_ROUNDS);
            r_cycles <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_err_set)      r_err <= 1'b1;
            else if (w_clr_err) r_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    for (int w = 0; w < 10; w++)
                        for (int b = 0; b < 4; b++)
                            if (w_state_wr && bus.reg_addr == 4'(w) && bus.reg_we[b])
                                r_buf[32*w+8*b +: 8] <= bus.reg_di[8*b +: 8];
                    if (w_ctrl_wr && bus.reg_we[0])
                        r_rounds <= bus.reg_di[4:0];
                    if (w_start_req && w_rounds_ok) begin
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_cycles <= '0;
                        r_state  <= S_START;
                    end
                end
                S_START: r_state <= S_WAIT;
                S_WAIT: begin
                    if (r_cycles != 8'hFF) r_cycles <= r_cycles + 8'd1;
                    if (bus.perm_ready) begin
                        r_state <= S_CAPTURE;
                    end else if (w_timeout) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_buf   <= bus.perm_s_out;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reads see pre-edge register values, so a same-cycle write returns old data
    always_comb begin
        w_rd_data = '0;
        for (int w = 0; w < 10; w++)
            if (bus.reg_addr == 4'(w)) w_rd_data = r_buf[32*w +: 32];
        if (bus.reg_addr == 4'd10)
            w_rd_data = {16'b0, r_busy, r_done, r_err, 8'b0, r_rounds};
        else if (bus.reg_addr == 4'd11)
            w_rd_data = {24'b0, r_cycles};
    end

    assign bus.reg_wait    = bus.reg_re && r_busy &&
                             ((bus.reg_addr < 4'd10) || (bus.reg_addr == 4'd11));
    assign bus.reg_do      = (bus.reg_re && !bus.reg_wait) ? w_rd_data : 32'h0;
    assign bus.perm_start  = (r_state == S_START);
    assign bus.perm_rounds = r_rounds;
    assign bus.perm_s_in   = r_buf;
endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: register vector table plus hand-written
// sequences for completion, read stall, busy errors, timeout and async reset.
module tb_ascon_perm_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    ascon_perm_ctrl_if bus();
    ascon_perm_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    // Core model: ready after `lat` WAIT cycles unless disabled
    logic [319:0] core_out;
    int           lat = 12;
    bit           core_en = 1'b1;
    logic         act;
    int           ccnt;
    assign bus.perm_s_out = core_out;
    assign bus.perm_ready = act && core_en && (ccnt == lat - 1);
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            act  <= 1'b0;
            ccnt <= 0;
        end else if (bus.perm_start) begin
            act  <= 1'b1;
            ccnt <= 0;
        end else if (act) begin
            ccnt <= ccnt + 1;
            if (bus.perm_ready) act <= 1'b0;
        end
    end

    int           pulses = 0;
    logic [319:0] st_sin;
    logic [4:0]   st_rnd;
    always @(posedge clk) begin
        if (bus.perm_start === 1'b1) begin
            pulses = pulses + 1;
            st_sin = bus.perm_s_in;
            st_rnd = bus.perm_rounds;
        end
    end

    task automatic chk(input string nm, input logic [319:0] act_v, input logic [319:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        bus.reg_re   = 1'b0;
        bus.reg_addr = a;
        bus.reg_we   = we;
        bus.reg_di   = d;
        @(negedge clk);
        bus.reg_we   = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.reg_we   = 4'h0;
        bus.reg_addr = a;
        bus.reg_re   = 1'b1;
        #1;
        d = bus.reg_do;
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  we;
        logic [31:0] di;
        logic        re;
        logic [31:0] exp_do;
        string       name;
    } vec_t;

    vec_t         vq[$];
    logic [319:0] loaded, exp_buf;
    logic [31:0]  d;
    int           p0, waited, k;

    initial begin
        bus.reg_addr = '0; bus.reg_we = '0; bus.reg_di = '0; bus.reg_re = 1'b0;
        for (int i = 0; i < 10; i++) core_out[32*i +: 32] = 32'hC0DE0000 + 32'(i) * 32'h00010101;
        for (int i = 0; i < 10; i++) loaded[32*i +: 32] = 32'(i);

        #12;
        chk("rst_start",  320'(bus.perm_start),  320'd0);
        chk("rst_wait",   320'(bus.reg_wait),    320'd0);
        chk("rst_do",     320'(bus.reg_do),      320'd0);
        chk("rst_sin",    bus.perm_s_in,         320'd0);
        chk("rst_rounds", 320'(bus.perm_rounds), 320'd12);
        @(negedge clk);
        resetn = 1'b1;

        vq.push_back('{4'd10, 4'h0, 32'h0,        1'b1, 32'h0000000C, "ctrl_rst"});
        vq.push_back('{4'd0,  4'h0, 32'h0,        1'b1, 32'h00000000, "w0_rst"});
        vq.push_back('{4'd11, 4'h0, 32'h0,        1'b1, 32'h00000000, "cyc_rst"});
        vq.push_back('{4'd0,  4'hF, 32'h11223344, 1'b0, 32'h0,        "w0_wr"});
        vq.push_back('{4'd0,  4'h4, 32'hAABBCCDD, 1'b1, 32'h11223344, "rd_old_on_wr"});
        vq.push_back('{4'd0,  4'h0, 32'h0,        1'b1, 32'h11BB3344, "byte_en"});
        vq.push_back('{4'd9,  4'h3, 32'hDEADBEEF, 1'b0, 32'h0,        "w9_wr"});
        vq.push_back('{4'd9,  4'h0, 32'h0,        1'b1, 32'h0000BEEF, "w9_lo16"});
        vq.push_back('{4'd13, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        "a13_wr"});
        vq.push_back('{4'd13, 4'h0, 32'h0,        1'b1, 32'h00000000, "a13_rd"});
        vq.push_back('{4'd10, 4'h1, 32'h00000005, 1'b0, 32'h0,        "rnd5_wr"});
        vq.push_back('{4'd10, 4'h0, 32'h0,        1'b1, 32'h00000005, "rnd5_rd"});
        vq.push_back('{4'd10, 4'h3, 32'h00000100, 1'b0, 32'h0,        "start_r0"});
        vq.push_back('{4'd10, 4'h0, 32'h0,        1'b1, 32'h00002000, "err_r0"});
        vq.push_back('{4'd10, 4'h3, 32'h0000010D, 1'b0, 32'h0,        "start_r13"});
        vq.push_back('{4'd10, 4'h0, 32'h0,        1'b1, 32'h0000200D, "err_r13"});
        vq.push_back('{4'd10, 4'h2, 32'h00000200, 1'b0, 32'h0,        "err_clr"});
        vq.push_back('{4'd10, 4'h0, 32'h0,        1'b1, 32'h0000000D, "err_cleared"});

        foreach (vq[i]) begin
            @(negedge clk);
            bus.reg_addr = vq[i].addr;
            bus.reg_we   = vq[i].we;
            bus.reg_di   = vq[i].di;
            bus.reg_re   = vq[i].re;
            #1;
            if (vq[i].re) chk(vq[i].name, 320'(bus.reg_do), 320'(vq[i].exp_do));
            chk({vq[i].name, "_nostall"}, 320'(bus.reg_wait),   320'd0);
            chk({vq[i].name, "_nopulse"}, 320'(bus.perm_start), 320'd0);
        end
        @(negedge clk);
        bus.reg_we = 4'h0; bus.reg_re = 1'b0;
        chk("bad_start_pulses", 320'(pulses), 320'd0);

        // Normal permutation with a state read stalled across the run
        for (int i = 0; i < 10; i++) wr(4'(i), 4'hF, 32'(i));
        lat = 12; core_en = 1'b1; p0 = pulses;
        wr(4'd10, 4'h3, 32'h0000010C);
        bus.reg_addr = 4'd3; bus.reg_re = 1'b1;
        waited = 0;
        for (k = 0; k < 100; k++) begin
            #1;
            if (!bus.reg_wait) break;
            waited++;
            @(negedge clk);
        end
        chk("stall_cycles", 320'(waited), 320'd14);
        chk("w3_after_cap", 320'(bus.reg_do), 320'(core_out[127:96]));
        chk("a_pulses", 320'(pulses - p0), 320'd1);
        chk("a_rounds", 320'(st_rnd), 320'd12);
        chk("a_sin",    st_sin, loaded);
        rd(4'd10, d); chk("a_ctrl", 320'(d), 320'h400C);
        rd(4'd11, d); chk("a_cycles", 320'(d), 320'd12);
        chk("a_buf", bus.perm_s_in, core_out);

        // Writes and restarts while busy are dropped and flag err
        lat = 20; p0 = pulses;
        wr(4'd10, 4'h3, 32'h0000010C);
        wr(4'd0, 4'hF, 32'hFFFFFFFF);
        #1 chk("busy_wr_dropped", 320'(bus.perm_s_in[31:0]), 320'(core_out[31:0]));
        wr(4'd10, 4'h3, 32'h00000105);
        rd(4'd10, d); chk("b_ctrl_busy", 320'(d), 320'hA00C);
        chk("b_rounds_stable", 320'(bus.perm_rounds), 320'd12);
        for (k = 0; k < 100; k++) begin
            rd(4'd10, d);
            if (!d[15]) break;
        end
        chk("b_done_bound", 320'(k < 100), 320'd1);
        chk("b_ctrl_done", 320'(d), 320'h600C);
        chk("b_pulses", 320'(pulses - p0), 320'd1);
        wr(4'd10, 4'h2, 32'h00000200);
        rd(4'd10, d); chk("b_err_clr", 320'(d), 320'h400C);

        // Core never answers: abort on timeout, buffer untouched
        core_en = 1'b0; p0 = pulses;
        wr(4'd0, 4'hF, 32'h12345678);
        exp_buf = core_out; exp_buf[31:0] = 32'h12345678;
        wr(4'd10, 4'h3, 32'h0000010C);
        for (k = 0; k < 400; k++) begin
            rd(4'd10, d);
            if (!d[15]) break;
        end
        chk("c_abort_bound", 320'(k < 400), 320'd1);
        chk("c_ctrl", 320'(d), 320'h200C);
        rd(4'd11, d); chk("c_cycles", 320'(d), 320'd255);
        chk("c_buf", bus.perm_s_in, exp_buf);
        chk("c_pulses", 320'(pulses - p0), 320'd1);

        // Async reset while in WAIT
        core_en = 1'b1; lat = 50;
        wr(4'd10, 4'h2, 32'h00000200);
        wr(4'd10, 4'h3, 32'h00000107);
        repeat (5) @(negedge clk);
        bus.reg_addr = 4'd10; bus.reg_re = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("d_start",  320'(bus.perm_start),  320'd0);
        chk("d_ctrl",   320'(bus.reg_do),      320'h0000000C);
        chk("d_sin",    bus.perm_s_in,         320'd0);
        chk("d_rounds", 320'(bus.perm_rounds), 320'd12);
        @(negedge clk);
        resetn = 1'b1;
        rd(4'd11, d); chk("d_cycles", 320'(d), 320'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
